// File: rtl/pll_cfg_seq.sv
// Purpose : writes M/N/C0 counter words into the PLL reconfiguration core over
//           its management port, starts the reconfiguration, then waits for re-lock.
// Latency : 1 accept cycle + 5 writes (+1 per waitrequest stall) + up to LOSS_WAIT unlock
//           cycles + 2 synchroniser cycles + LOCK_STABLE (or LOCK_TIMEOUT -> error).
// Backpressure: mgmt_waitrequest holds the current write indefinitely; cfg_req is
//           ignored while cfg_busy is high.
// Ports   : refclk/rst (sync, active-high); cfg_req + cfg_m/n/c0 request; cfg_busy,
//           cfg_done (pulse), cfg_error (sticky) status; pll_locked (async input);
//           mgmt_address/write/writedata/waitrequest Avalon-MM management master.
module pll_cfg_seq #(
  parameter int LOSS_WAIT    = 256,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_c0,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest
);

  localparam int LW_W = $clog2(LOSS_WAIT + 1);
  localparam int LS_W = $clog2(LOCK_STABLE + 1);
  localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [LW_W-1:0] LW_MAX  = LW_W'(LOSS_WAIT);
  localparam logic [LW_W-1:0] LW_LAST = LW_W'(LOSS_WAIT - 1);
  localparam logic [LS_W-1:0] LS_MAX  = LS_W'(LOCK_STABLE);
  localparam logic [LT_W-1:0] LT_MAX  = LT_W'(LOCK_TIMEOUT);
  localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_M, S_WR_N, S_WR_C0, S_WR_START,
    S_WAIT_UNLOCK, S_WAIT_LOCK, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_n;
  logic [17:0]     m_q, n_q, c0_q;
  logic            sync1, lk;
  logic [LW_W-1:0] unl_cnt, unl_n;
  logic [LS_W-1:0] stb_cnt, stb_n;
  logic [LT_W-1:0] tmo_cnt, tmo_n;
  logic            accept;
  logic            busy_n, done_n, error_n, write_n;
  logic [5:0]      addr_n;
  logic [31:0]     data_n;

  // Management word (address, data) issued in each write state.
  function automatic logic [37:0] wr_cmd(input state_t s, input logic [17:0] m,
                                         input logic [17:0] n, input logic [17:0] c0);
    case (s)
      S_WR_M:     wr_cmd = {6'h04, 14'b0, m};
      S_WR_N:     wr_cmd = {6'h03, 14'b0, n};
      S_WR_C0:    wr_cmd = {6'h05, 9'b0, 5'd0, c0};   // counter select 0 = C0
      S_WR_START: wr_cmd = {6'h02, 32'd1};
      default:    wr_cmd = {6'h00, 32'd0};            // mode register: waitrequest mode
    endcase
  endfunction

  function automatic state_t next_wr(input state_t s);
    case (s)
      S_WR_MODE: next_wr = S_WR_M;
      S_WR_M:    next_wr = S_WR_N;
      S_WR_N:    next_wr = S_WR_C0;
      S_WR_C0:   next_wr = S_WR_START;
      default:   next_wr = S_WAIT_UNLOCK;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    busy_n  = cfg_busy;
    done_n  = 1'b0;
    error_n = cfg_error;
    write_n = mgmt_write;
    addr_n  = mgmt_address;
    data_n  = mgmt_writedata;
    unl_n   = '0;
    stb_n   = '0;
    tmo_n   = '0;
    case (state)
      S_IDLE: begin
        if (cfg_req) begin
          accept  = 1'b1;
          busy_n  = 1'b1;
          error_n = 1'b0;
          state_n = S_WR_MODE;
        end
      end
      S_WR_MODE, S_WR_M, S_WR_N, S_WR_C0, S_WR_START: begin
        // Only WR_MODE is entered with the strobe low; later writes are loaded
        // back-to-back on the completing edge of the previous one.
        if (!mgmt_write) begin
          write_n          = 1'b1;
          {addr_n, data_n} = wr_cmd(state, m_q, n_q, c0_q);
        end else if (!mgmt_waitrequest) begin
          state_n = next_wr(state);
          if (state_n == S_WAIT_UNLOCK) begin
            write_n = 1'b0;
            addr_n  = '0;
            data_n  = '0;
          end else begin
            {addr_n, data_n} = wr_cmd(state_n, m_q, n_q, c0_q);
          end
        end
      end
      S_WAIT_UNLOCK: begin
        // A reconfiguration to the same setting may never drop lock, so the
        // bounded wait simply expires into the lock wait.
        if (!lk || unl_cnt == LW_LAST) begin
          state_n = S_WAIT_LOCK;
        end else begin
          unl_n = (unl_cnt == LW_MAX) ? unl_cnt : unl_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        stb_n = !lk ? '0 : ((stb_cnt == LS_MAX) ? stb_cnt : stb_cnt + 1'b1);
        tmo_n = (tmo_cnt == LT_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
        // Stable lock is checked first so it wins a same-cycle timeout.
        if (stb_n == LS_MAX) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (tmo_cnt == LT_LAST) begin
          state_n = S_ERROR;
          busy_n  = 1'b0;
          error_n = 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state          <= S_IDLE;
      m_q            <= '0;
      n_q            <= '0;
      c0_q           <= '0;
      sync1          <= 1'b0;
      lk             <= 1'b0;
      unl_cnt        <= '0;
      stb_cnt        <= '0;
      tmo_cnt        <= '0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else begin
      state          <= state_n;
      sync1          <= pll_locked;
      lk             <= sync1;
      unl_cnt        <= unl_n;
      stb_cnt        <= stb_n;
      tmo_cnt        <= tmo_n;
      cfg_busy       <= busy_n;
      cfg_done       <= done_n;
      cfg_error      <= error_n;
      mgmt_write     <= write_n;
      mgmt_address   <= addr_n;
      mgmt_writedata <= data_n;
      if (accept) begin
        m_q  <= cfg_m;
        n_q  <= cfg_n;
        c0_q <= cfg_c0;
      end
    end
  end

endmodule

// File: tb/tb_pll_cfg_seq.sv
module tb_pll_cfg_seq;

  localparam int LOSS_WAIT    = 256;
  localparam int LOCK_STABLE  = 16;
  localparam int LOCK_TIMEOUT = 1000;
  localparam int MAXC         = 2047;

  logic        refclk = 1'b0;
  logic        rst;
  logic        cfg_req;
  logic [17:0] cfg_m, cfg_n, cfg_c0;
  logic        cfg_busy, cfg_done, cfg_error;
  logic        pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  pll_cfg_seq #(
    .LOSS_WAIT(LOSS_WAIT), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_req(cfg_req),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c0(cfg_c0),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest)
  );

  always #10 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct { logic [5:0] addr; logic [31:0] data; int at; } wr_exp_t;
  typedef struct { bit is_err; int at; } ev_exp_t;

  wr_exp_t wq[$];
  ev_exp_t eq[$];

  // ws[j]: waitrequest sampled at edge base+j; raw[j]: pll_locked driven after edge base+j.
  bit ws[0:MAXC];
  bit raw[0:MAXC];
  bit raw_init;
  int base = 0;
  int end_rel;
  bit exp_err;
  bit err_prev = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit ws_at(input int j);
    if (j < 0 || j > MAXC) return 1'b0;
    return ws[j];
  endfunction

  function automatic bit raw_at(input int j);
    if (j < 0) return raw_init;
    if (j > MAXC) return raw[MAXC];
    return raw[j];
  endfunction

  // Synchronised lock as seen at edge base+e: two flops behind the raw pin.
  function automatic bit lkv(input int e);
    return raw_at(e - 3);
  endfunction

  // Reference model: predicts completed writes and the done/error edge.
  function automatic void model(input logic [17:0] m, input logic [17:0] n,
                                input logic [17:0] c0, input int rst_at);
    logic [5:0]  ad[5];
    logic [31:0] dt[5];
    int s, u, e, l, run;
    ad[0] = 6'h00; dt[0] = 32'd0;
    ad[1] = 6'h04; dt[1] = {14'b0, m};
    ad[2] = 6'h03; dt[2] = {14'b0, n};
    ad[3] = 6'h05; dt[3] = {9'b0, 5'd0, c0};
    ad[4] = 6'h02; dt[4] = 32'd1;
    exp_err = 1'b0;
    s = 2;
    for (int k = 0; k < 5; k++) begin
      while (ws_at(s)) s++;
      if (rst_at >= 0 && s >= rst_at) begin
        end_rel = rst_at;
        return;
      end
      wq.push_back('{ad[k], dt[k], s});
      s++;
    end
    u = s - 1;
    e = u + 1;
    while (lkv(e) && (e - u - 1) != LOSS_WAIT - 1) e++;
    l = e;
    run = 0;
    for (int g = 0; g < MAXC; g++) begin
      e = l + 1 + g;
      run = lkv(e) ? run + 1 : 0;
      if (run >= LOCK_STABLE) begin
        eq.push_back('{1'b0, e});
        break;
      end
      if (e - l - 1 == LOCK_TIMEOUT - 1) begin
        eq.push_back('{1'b1, e});
        exp_err = 1'b1;
        break;
      end
    end
    end_rel = e;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic clear_ws();
    for (int j = 0; j <= MAXC; j++) ws[j] = 1'b0;
  endtask

  // Lock high until drop_at, low for drop_len, then (optionally) a relock_len
  // high run broken by one low cycle, then high for good.
  task automatic build_lock(input int drop_at, input int drop_len, input int relock_len);
    for (int j = 0; j <= MAXC; j++) begin
      if (j < drop_at) raw[j] = 1'b1;
      else if (j < drop_at + drop_len) raw[j] = 1'b0;
      else if (relock_len > 0 && j < drop_at + drop_len + relock_len) raw[j] = 1'b1;
      else if (relock_len > 0 && j == drop_at + drop_len + relock_len) raw[j] = 1'b0;
      else raw[j] = 1'b1;
    end
  endtask

  task automatic run_case(input string name, input logic [17:0] m, input logic [17:0] n,
                          input logic [17:0] c0, input int rst_at, input int req2_at);
    raw_init = pll_locked;
    model(m, n, c0, rst_at);
    base = cyc + 1;
    cfg_m = m; cfg_n = n; cfg_c0 = c0;
    cfg_req = 1'b1;
    mgmt_waitrequest = ws_at(0);
    for (int rel = 0; rel <= end_rel + 4; rel++) begin
      tick();
      cfg_req          = (rel + 1 == req2_at);
      rst              = (rel + 1 == rst_at);
      mgmt_waitrequest = ws_at(rel + 1);
      pll_locked       = raw_at(rel);
      if (rel == 0) begin
        chk({name, "_busy_on_accept"}, 64'(cfg_busy), 64'd1);
        chk({name, "_error_cleared"}, 64'(cfg_error), 64'd0);
        cfg_m  = 18'($urandom);
        cfg_n  = 18'($urandom);
        cfg_c0 = 18'($urandom);
      end
      if (rel == rst_at) begin
        chk({name, "_write_after_rst"}, 64'(mgmt_write), 64'd0);
        chk({name, "_busy_after_rst"}, 64'(cfg_busy), 64'd0);
      end
    end
    chk({name, "_writes_left"}, 64'(wq.size()), 64'd0);
    chk({name, "_events_left"}, 64'(eq.size()), 64'd0);
    chk({name, "_busy_end"}, 64'(cfg_busy), 64'd0);
    chk({name, "_error_end"}, 64'(cfg_error), 64'(exp_err));
    wq.delete();
    eq.delete();
    repeat (4) tick();
  endtask

  // Monitor: pops expectations whenever the DUT completes a write or reports.
  always @(negedge refclk) begin : mon
    wr_exp_t w;
    ev_exp_t v;
    if (mgmt_write === 1'b1 && mgmt_waitrequest === 1'b0) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: addr=0x%0h data=0x%0h edge=%0d, none expected",
                 mgmt_address, mgmt_writedata, cyc + 1 - base);
      end else begin
        w = wq.pop_front();
        if (mgmt_address !== w.addr || mgmt_writedata !== w.data || (cyc + 1 - base) != w.at) begin
          failures++;
          $display("FAIL write: got addr=0x%0h data=0x%0h edge=%0d expected addr=0x%0h data=0x%0h edge=%0d",
                   mgmt_address, mgmt_writedata, cyc + 1 - base, w.addr, w.data, w.at);
        end
      end
    end
    if (cfg_done === 1'b1 || (cfg_error === 1'b1 && !err_prev)) begin
      checks++;
      if (eq.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected: done=%0b error=%0b edge=%0d", cfg_done, cfg_error, cyc - base);
      end else begin
        v = eq.pop_front();
        if (cfg_done !== !v.is_err || (cyc - base) != v.at) begin
          failures++;
          $display("FAIL event: got done=%0b edge=%0d expected done=%0b edge=%0d",
                   cfg_done, cyc - base, !v.is_err, v.at);
        end
      end
      chk("busy_at_report", 64'(cfg_busy), 64'd0);
      if (cfg_done === 1'b1) chk("error_with_done", 64'(cfg_error), 64'd0);
    end
    err_prev = (cfg_error === 1'b1);
  end

  initial begin
    rst = 1'b1;
    cfg_req = 1'b0;
    cfg_m = '0; cfg_n = '0; cfg_c0 = '0;
    pll_locked = 1'b1;
    mgmt_waitrequest = 1'b0;
    clear_ws();
    build_lock(0, 0, 0);
    repeat (3) tick();
    chk("rst_busy", 64'(cfg_busy), 64'd0);
    chk("rst_done", 64'(cfg_done), 64'd0);
    chk("rst_error", 64'(cfg_error), 64'd0);
    chk("rst_write", 64'(mgmt_write), 64'd0);
    chk("rst_address", 64'(mgmt_address), 64'd0);
    chk("rst_writedata", 64'(mgmt_writedata), 64'd0);
    rst = 1'b0;
    repeat (3) tick();

    clear_ws(); build_lock(8, 10, 0);
    run_case("basic", 18'h00303, 18'h10000, 18'h20201, -1, -1);

    clear_ws(); for (int j = 4; j <= 6; j++) ws[j] = 1'b1; build_lock(12, 10, 0);
    run_case("stall", 18'($urandom), 18'($urandom), 18'($urandom), -1, -1);

    clear_ws(); build_lock(0, 0, 0);
    run_case("no_drop", 18'($urandom), 18'($urandom), 18'($urandom), -1, -1);

    clear_ws(); build_lock(8, MAXC + 1, 0);
    run_case("timeout", 18'($urandom), 18'($urandom), 18'($urandom), -1, -1);

    clear_ws(); build_lock(8, 10, 10);
    run_case("glitch", 18'($urandom), 18'($urandom), 18'($urandom), -1, -1);

    clear_ws(); for (int j = 5; j <= 7; j++) ws[j] = 1'b1; build_lock(0, 0, 0);
    run_case("reset_mid", 18'($urandom), 18'($urandom), 18'($urandom), 6, -1);

    clear_ws(); build_lock(8, 6, 0);
    run_case("ignored_req", 18'($urandom), 18'($urandom), 18'($urandom), -1, 3);

    for (int r = 0; r < 4; r++) begin
      clear_ws();
      for (int j = 1; j <= 30; j++) ws[j] = ($urandom_range(0, 3) == 0);
      build_lock($urandom_range(6, 30), $urandom_range(0, 25),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0);
      run_case("random", 18'($urandom), 18'($urandom), 18'($urandom), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
